// File: rtl/sys_clk_en_rst_seq.sv
// Staged per-channel reset release plus divided clock-enable pulses, all in the clk_i domain.
// Outputs are registered; divisor updates wait for the channel's next reload so no period is cut short.
module sys_clk_en_rst_seq #(
  parameter int N_CH       = 4,
  parameter int DIV_WIDTH  = 8,
  parameter int HOLD_WIDTH = 4,
  parameter int DEF_DIV    = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_CH*DIV_WIDTH-1:0] div_i,
  input  logic                      div_load_i,
  input  logic [HOLD_WIDTH-1:0]     hold_i,
  input  logic                      soft_rst_i,
  output logic [N_CH-1:0]           ce_o,
  output logic [N_CH-1:0]           ch_rst_o,
  output logic                      ready_o
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DEF_DIV);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [HOLD_WIDTH-1:0] hc_q, hc_d;
  logic [HOLD_WIDTH-1:0] h_q, h_d, h_cur;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N_CH-1:0]       ch_rst_q, ch_rst_d;
  logic                  ready_q, ready_d;
  logic                  load_cap;

  // A divisor of zero behaves as one, so the reload value saturates at zero.
  function automatic logic [DIV_WIDTH-1:0] eff_m1(input logic [DIV_WIDTH-1:0] d);
    eff_m1 = (d == '0) ? '0 : d - DIV_WIDTH'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_ASSERT;
      hc_q     <= '0;
      h_q      <= '0;
      idx_q    <= '0;
      ch_rst_q <= '1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      h_q      <= h_d;
      idx_q    <= idx_d;
      ch_rst_q <= ch_rst_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    h_d      = h_q;
    idx_d    = idx_q;
    ch_rst_d = ch_rst_q;
    ready_d  = ready_q;
    // The first ASSERT edge of a sequence samples the gap directly, then it is frozen.
    h_cur    = (state_q == ST_ASSERT && hc_q == '0) ? hold_i : h_q;
    if (soft_rst_i) begin
      state_d  = ST_ASSERT;
      hc_d     = '0;
      idx_d    = '0;
      h_d      = hold_i;
      ch_rst_d = '1;
      ready_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          ch_rst_d = '1;
          ready_d  = 1'b0;
          h_d      = h_cur;
          if (hc_q == h_cur) begin
            state_d = ST_RELEASE;
            hc_d    = '0;
            idx_d   = '0;
          end else begin
            hc_d = hc_q + HOLD_WIDTH'(1);
          end
        end
        ST_RELEASE: begin
          if (hc_q == h_q) begin
            ch_rst_d[idx_q] = 1'b0;
            hc_d            = '0;
            idx_d           = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(N_CH - 1)) begin
              state_d = ST_DONE;
              ready_d = 1'b1;
              idx_d   = '0;
            end
          end else begin
            hc_d = hc_q + HOLD_WIDTH'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_ASSERT;
        end
      endcase
    end
  end

  assign load_cap = div_load_i && (state_q != ST_ASSERT);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DIV_WIDTH-1:0] div_k;
    logic [DIV_WIDTH-1:0] d_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] pend_dat_q;
    logic                 pend_vld_q;
    logic                 ce_q;

    assign div_k = div_i[k*DIV_WIDTH +: DIV_WIDTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        d_q        <= RST_DIV;
        cnt_q      <= eff_m1(RST_DIV);
        pend_dat_q <= '0;
        pend_vld_q <= 1'b0;
        ce_q       <= 1'b0;
      end else if (soft_rst_i) begin
        d_q        <= div_k;
        cnt_q      <= eff_m1(d_q);
        pend_vld_q <= 1'b0;
        ce_q       <= 1'b0;
      end else begin
        if (state_q == ST_ASSERT) begin
          d_q <= div_k;
        end else if (load_cap) begin
          pend_dat_q <= div_k;
          pend_vld_q <= 1'b1;
        end
        if (ch_rst_q[k]) begin
          ce_q  <= 1'b0;
          cnt_q <= eff_m1(d_q);
        end else if (cnt_q == '0) begin
          ce_q <= 1'b1;
          if (pend_vld_q) begin
            // Adopt on the reload edge; a load landing on this same edge stays pending.
            d_q   <= pend_dat_q;
            cnt_q <= eff_m1(pend_dat_q);
            if (!load_cap) begin
              pend_vld_q <= 1'b0;
            end
          end else begin
            cnt_q <= eff_m1(d_q);
          end
        end else begin
          ce_q  <= 1'b0;
          cnt_q <= cnt_q - DIV_WIDTH'(1);
        end
      end
    end

    assign ce_o[k] = ce_q;
  end

  assign ch_rst_o = ch_rst_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_sys_clk_en_rst_seq.sv
// Directed checks of reset sequencing, divided enables, divisor hand-over and both reset paths.
module tb_sys_clk_en_rst_seq;
  localparam int N_CH = 4;
  localparam int DW   = 8;
  localparam int HW   = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b0;
  logic [N_CH*DW-1:0]   div_i = '0;
  logic                 div_load_i = 1'b0;
  logic [HW-1:0]        hold_i = '0;
  logic                 soft_rst_i = 1'b0;
  logic [N_CH-1:0]      ce_o;
  logic [N_CH-1:0]      ch_rst_o;
  logic                 ready_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  sys_clk_en_rst_seq #(
    .N_CH(N_CH), .DIV_WIDTH(DW), .HOLD_WIDTH(HW), .DEF_DIV(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .div_i(div_i), .div_load_i(div_load_i),
    .hold_i(hold_i), .soft_rst_i(soft_rst_i), .ce_o(ce_o),
    .ch_rst_o(ch_rst_o), .ready_o(ready_o)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [N_CH*DW-1:0] divs(input int d0, input int d1, input int d2, input int d3);
    return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  // Leaves rst_i low just after an edge, so the next rising edge is edge 1.
  task automatic do_reset(input int h, input logic [N_CH*DW-1:0] d);
    hold_i     = HW'(h);
    div_i      = d;
    div_load_i = 1'b0;
    soft_rst_i = 1'b0;
    rst_i      = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    div_i = divs(1, 1, 1, 1);
    hold_i = 4'd2;
    #3 rst_i = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++; if (ch_rst_o !== 4'b1111) begin bad++; $display("FAIL reset_ch_rst pass=%0d got=%b want=1111", i, ch_rst_o); end
      total++; if (ce_o !== 4'b0000) begin bad++; $display("FAIL reset_ce pass=%0d got=%b want=0000", i, ce_o); end
      total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready pass=%0d got=%b want=0", i, ready_o); end
      tick();
    end
  endtask

  task automatic test_seq_h2;
    int fall[N_CH] = '{6, 9, 12, 15};
    logic [N_CH-1:0] exp_rst, exp_ce;
    do_reset(2, divs(1, 1, 1, 1));
    for (int e = 1; e <= 18; e++) begin
      tick();
      for (int k = 0; k < N_CH; k++) begin
        exp_rst[k] = (e < fall[k]);
        exp_ce[k]  = (e > fall[k]);
      end
      total++; if (ch_rst_o !== exp_rst) begin bad++; $display("FAIL h2_ch_rst edge=%0d got=%b want=%b", e, ch_rst_o, exp_rst); end
      total++; if (ce_o !== exp_ce) begin bad++; $display("FAIL h2_ce edge=%0d got=%b want=%b", e, ce_o, exp_ce); end
      total++; if (ready_o !== (e >= 15)) begin bad++; $display("FAIL h2_ready edge=%0d got=%b want=%b", e, ready_o, (e >= 15)); end
    end
  endtask

  // ch1 divides by 4, ch2 has divisor 0 and must behave like divisor 1.
  task automatic test_div4_div0;
    logic [N_CH-1:0] exp_rst, exp_ce;
    do_reset(0, divs(1, 4, 0, 1));
    for (int e = 1; e <= 16; e++) begin
      tick();
      for (int k = 0; k < N_CH; k++) exp_rst[k] = (e < k + 2);
      exp_ce[0] = (e >= 3);
      exp_ce[1] = (e == 7 || e == 11 || e == 15);
      exp_ce[2] = (e >= 5);
      exp_ce[3] = (e >= 6);
      total++; if (ch_rst_o !== exp_rst) begin bad++; $display("FAIL div4_ch_rst edge=%0d got=%b want=%b", e, ch_rst_o, exp_rst); end
      total++; if (ce_o !== exp_ce) begin bad++; $display("FAIL div4_ce edge=%0d got=%b want=%b", e, ce_o, exp_ce); end
      total++; if (ready_o !== (e >= 5)) begin bad++; $display("FAIL div4_ready edge=%0d got=%b want=%b", e, ready_o, (e >= 5)); end
    end
  endtask

  // ch0 runs at 5; loads of 7 then 3 mid-period: last write wins, taken at the next reload.
  task automatic test_div_change;
    logic exp;
    do_reset(0, divs(5, 1, 1, 1));
    for (int e = 1; e <= 24; e++) begin
      if (e == 10) begin div_i = divs(7, 1, 1, 1); div_load_i = 1'b1; end
      else if (e == 11) begin div_i = divs(3, 1, 1, 1); div_load_i = 1'b1; end
      else div_load_i = 1'b0;
      tick();
      exp = (e == 7 || e == 12 || e == 15 || e == 18 || e == 21 || e == 24);
      total++; if (ce_o[0] !== exp) begin bad++; $display("FAIL divchg_ce0 edge=%0d got=%b want=%b", e, ce_o[0], exp); end
    end
    div_load_i = 1'b0;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL divchg_ready got=%b want=1", ready_o); end
  endtask

  // From DONE: soft reset together with a load of 6; the load must be discarded.
  task automatic test_soft_rst;
    int fall[N_CH] = '{4, 6, 8, 10};
    logic [N_CH-1:0] exp_rst, exp_ce;
    hold_i     = 4'd1;
    div_i      = divs(6, 6, 6, 6);
    div_load_i = 1'b1;
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    div_load_i = 1'b0;
    div_i      = divs(1, 1, 1, 1);
    total++; if (ch_rst_o !== 4'b1111) begin bad++; $display("FAIL soft_ch_rst got=%b want=1111", ch_rst_o); end
    total++; if (ce_o !== 4'b0000) begin bad++; $display("FAIL soft_ce got=%b want=0000", ce_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL soft_ready got=%b want=0", ready_o); end
    for (int n = 1; n <= 16; n++) begin
      tick();
      for (int k = 0; k < N_CH; k++) begin
        exp_rst[k] = (n < fall[k]);
        exp_ce[k]  = (n > fall[k]);
      end
      total++; if (ch_rst_o !== exp_rst) begin bad++; $display("FAIL soft_seq_ch_rst edge=%0d got=%b want=%b", n, ch_rst_o, exp_rst); end
      total++; if (ce_o !== exp_ce) begin bad++; $display("FAIL soft_seq_ce edge=%0d got=%b want=%b", n, ce_o, exp_ce); end
      total++; if (ready_o !== (n >= 10)) begin bad++; $display("FAIL soft_seq_ready edge=%0d got=%b want=%b", n, ready_o, (n >= 10)); end
    end
  endtask

  task automatic test_async_rst;
    int fall[N_CH] = '{6, 9, 12, 15};
    logic [N_CH-1:0] exp_rst;
    do_reset(2, divs(1, 1, 1, 1));
    for (int e = 1; e <= 7; e++) tick();
    total++; if (ch_rst_o !== 4'b1110) begin bad++; $display("FAIL arst_pre got=%b want=1110", ch_rst_o); end
    #3 rst_i = 1'b1;
    #1;
    total++; if (ch_rst_o !== 4'b1111) begin bad++; $display("FAIL arst_ch_rst got=%b want=1111", ch_rst_o); end
    total++; if (ce_o !== 4'b0000) begin bad++; $display("FAIL arst_ce got=%b want=0000", ce_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL arst_ready got=%b want=0", ready_o); end
    tick();
    rst_i = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      for (int k = 0; k < N_CH; k++) exp_rst[k] = (e < fall[k]);
      total++; if (ch_rst_o !== exp_rst) begin bad++; $display("FAIL arst_seq_ch_rst edge=%0d got=%b want=%b", e, ch_rst_o, exp_rst); end
      total++; if (ready_o !== (e >= 15)) begin bad++; $display("FAIL arst_seq_ready edge=%0d got=%b want=%b", e, ready_o, (e >= 15)); end
      total++; if (ce_o[0] !== (e > 6)) begin bad++; $display("FAIL arst_seq_ce0 edge=%0d got=%b want=%b", e, ce_o[0], (e > 6)); end
    end
  endtask

  initial begin
    test_reset();
    test_seq_h2();
    test_div4_div0();
    test_div_change();
    test_soft_rst();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
